// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_oversample
// Brief   : 8-bit UART receiver on a 16x sample clock. Optional parity and
//           1/1.5/2 stop bits. Define UART_RX_MAJORITY_EN for 2-of-3 voting.
// Rev     : 1.0  initial release
// ============================================================================
module uart_rx_oversample (
  input  logic       clk_sample,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] parity_mode,
  input  logic [1:0] stop_bit,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [4:0] SAMPLE_TICK = 5'd9;
`else
  localparam logic [4:0] SAMPLE_TICK = 5'd8;
`endif
  localparam logic [4:0] BIT_LAST_TICK = 5'd15;

  logic       rx_meta_q, rx_s_q, rx_prev_q;
  state_t     state_q, state_d;
  logic [4:0] tick_q, tick_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [1:0] par_mode_q, par_mode_d;
  logic [1:0] stop_mode_q, stop_mode_d;
  logic [7:0] shift_q, shift_d;
  logic       par_sample_q, par_sample_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       ready_q, ready_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       brk_q, brk_d;

  logic       fall_w;
  logic       bit_val_w;
  logic       at_sample_w;
  logic       at_bit_end_w;
  logic       par_en_w;
  logic       exp_par_w;
  logic [4:0] stop_last_w;

  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // A held-low line (break) never produces this edge, so after a framing
  // error nothing restarts until rx_s has been high again.
  assign fall_w = rx_prev_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_EN
  logic vote7_q, vote8_q;

  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      vote7_q <= 1'b1;
      vote8_q <= 1'b1;
    end else begin
      if (tick_q == 5'd7) vote7_q <= rx_s_q;
      if (tick_q == 5'd8) vote8_q <= rx_s_q;
    end
  end

  assign bit_val_w = (vote7_q & vote8_q) | (vote7_q & rx_s_q) | (vote8_q & rx_s_q);
`else
  assign bit_val_w = rx_s_q;
`endif

  assign at_sample_w  = (tick_q == SAMPLE_TICK);
  assign at_bit_end_w = (tick_q == BIT_LAST_TICK);
  assign par_en_w     = (par_mode_q == 2'd1) || (par_mode_q == 2'd2);
  assign exp_par_w    = (^shift_q) ^ (par_mode_q == 2'd2);

  always_comb begin
    unique case (stop_mode_q)
      2'd0:    stop_last_w = 5'd15;
      2'd1:    stop_last_w = 5'd23;
      default: stop_last_w = 5'd31;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q + 5'd1;
    bit_idx_d    = bit_idx_q;
    par_mode_d   = par_mode_q;
    stop_mode_d  = stop_mode_q;
    shift_d      = shift_q;
    par_sample_d = par_sample_q;
    rx_data_d    = rx_data_q;
    ready_d      = ready_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    brk_d        = brk_q;

    unique case (state_q)
      IDLE: begin
        tick_d = 5'd0;
        if (fall_w) state_d = START;
      end

      START: begin
        if (at_sample_w) begin
          if (bit_val_w) begin
            state_d = IDLE;
            tick_d  = 5'd0;
          end else begin
            // Jump 16 ahead: the rest of the start bit runs on ticks 25..31
            // and wraps to 0 exactly at the first data bit boundary.
            state_d     = DATA;
            tick_d      = tick_q + 5'd17;
            bit_idx_d   = 3'd0;
            par_mode_d  = parity_mode;
            stop_mode_d = stop_bit;
            ready_d     = 1'b0;
            perr_d      = 1'b0;
            ferr_d      = 1'b0;
            brk_d       = 1'b0;
          end
        end
      end

      DATA: begin
        if (at_sample_w) begin
          shift_d   = {bit_val_w, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
        if (at_bit_end_w) begin
          tick_d = 5'd0;
          // Index has wrapped back to 0 once all eight bits are in.
          if (bit_idx_q == 3'd0) state_d = par_en_w ? PARITY : STOP;
        end
      end

      PARITY: begin
        if (at_sample_w) par_sample_d = bit_val_w;
        if (at_bit_end_w) begin
          tick_d  = 5'd0;
          state_d = STOP;
        end
      end

      STOP: begin
        if (at_sample_w) begin
          rx_data_d = shift_q;
          ready_d   = 1'b1;
          ferr_d    = ~bit_val_w;
          perr_d    = par_en_w & (par_sample_q ^ exp_par_w);
          brk_d     = (shift_q == 8'h00) & ~bit_val_w & (~par_en_w | ~par_sample_q);
        end
        if (tick_q == stop_last_w) begin
          tick_d  = 5'd0;
          state_d = fall_w ? START : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= 5'd0;
      bit_idx_q    <= 3'd0;
      par_mode_q   <= 2'd0;
      stop_mode_q  <= 2'd0;
      shift_q      <= 8'h00;
      par_sample_q <= 1'b0;
      rx_data_q    <= 8'h00;
      ready_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_idx_q    <= bit_idx_d;
      par_mode_q   <= par_mode_d;
      stop_mode_q  <= stop_mode_d;
      shift_q      <= shift_d;
      par_sample_q <= par_sample_d;
      rx_data_q    <= rx_data_d;
      ready_q      <= ready_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      brk_q        <= brk_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_ready = ready_q;
  assign parity_err    = perr_q;
  assign frame_err     = ferr_q;
  assign break_det     = brk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_oversample
// Brief   : Directed self-checking bench for uart_rx_oversample.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx_oversample;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_NOPAR = 156;
  localparam logic [7:0] GLITCH_EXP = 8'h5A;
`else
  localparam int LAT_NOPAR = 155;
  localparam logic [7:0] GLITCH_EXP = 8'h5B;
`endif

  logic       clk_sample = 1'b0;
  logic       rst;
  logic       rx;
  logic [1:0] parity_mode;
  logic [1:0] stop_bit;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_cnt;

  uart_rx_oversample dut (
    .clk_sample    (clk_sample),
    .rst           (rst),
    .rx            (rx),
    .parity_mode   (parity_mode),
    .stop_bit      (stop_bit),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .break_det     (break_det)
  );

  always #5 clk_sample = ~clk_sample;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk_sample);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input int stop_ticks, input int glitch_bit);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive_bit(d[i], 9);
        drive_bit(~d[i], 1);
        drive_bit(d[i], 6);
      end else begin
        drive_bit(d[i], 16);
      end
    end
    if (par_en) drive_bit(par_bit, 16);
    drive_bit(1'b1, stop_ticks);
  endtask

  // Counts edges after the one that first samples the start bit.
  task automatic measure_latency(output int cnt);
    cnt = 0;
    @(posedge clk_sample);
    while (cnt < 400) begin
      @(posedge clk_sample);
      cnt++;
      #1;
      if (rx_data_ready) break;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    rx          = 1'b1;
    parity_mode = 2'd0;
    stop_bit    = 2'd0;
    repeat (3) @(posedge clk_sample);
    #1;
    check_val("rst_data",  rx_data, 8'h00);
    check_val("rst_ready", rx_data_ready, 1'b0);
    check_val("rst_perr",  parity_err, 1'b0);
    check_val("rst_ferr",  frame_err, 1'b0);
    check_val("rst_brk",   break_det, 1'b0);
    rst = 1'b0;
    repeat (5) @(posedge clk_sample);
    #1;

    // Short low pulse is rejected as a glitch.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check_val("glitch_ready", rx_data_ready, 1'b0);
    check_val("glitch_data",  rx_data, 8'h00);

    // 0xA5, no parity, one stop bit, with latency measurement.
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 16, -1);
      measure_latency(lat_cnt);
    join
    check_val("a5_latency", lat_cnt, LAT_NOPAR);
    check_val("a5_data",    rx_data, 8'hA5);
    check_val("a5_ready",   rx_data_ready, 1'b1);
    check_val("a5_perr",    parity_err, 1'b0);
    check_val("a5_ferr",    frame_err, 1'b0);
    check_val("a5_brk",     break_det, 1'b0);

    // 0x3C has even weight: even parity expects 0, so a sent 1 is an error.
    parity_mode = 2'd1;
    send_frame(8'h3C, 1'b1, 1'b1, 16, -1);
    check_val("even_data", rx_data, 8'h3C);
    check_val("even_perr", parity_err, 1'b1);
    check_val("even_ferr", frame_err, 1'b0);

    // Odd parity expects 1; the mid-frame switch to even must be ignored.
    parity_mode = 2'd2;
    fork
      send_frame(8'h3C, 1'b1, 1'b1, 16, -1);
      begin
        repeat (40) @(posedge clk_sample);
        #1 parity_mode = 2'd1;
      end
    join
    check_val("odd_data", rx_data, 8'h3C);
    check_val("odd_perr", parity_err, 1'b0);
    parity_mode = 2'd0;

    // Break: line low for 12 bit times.
    drive_bit(1'b0, 192);
    check_val("brk_data",  rx_data, 8'h00);
    check_val("brk_ready", rx_data_ready, 1'b1);
    check_val("brk_ferr",  frame_err, 1'b1);
    check_val("brk_det",   break_det, 1'b1);
    drive_bit(1'b1, 100);
    check_val("brk_hold_ready", rx_data_ready, 1'b1);
    check_val("brk_hold_data",  rx_data, 8'h00);

    // Back-to-back frames with two stop bits.
    stop_bit = 2'd2;
    send_frame(8'h55, 1'b0, 1'b0, 32, -1);
    check_val("b2b1_data",  rx_data, 8'h55);
    check_val("b2b1_ready", rx_data_ready, 1'b1);
    fork
      send_frame(8'h0F, 1'b0, 1'b0, 32, -1);
      begin
        repeat (30) @(posedge clk_sample);
        #1 check_val("b2b_ready_clear", rx_data_ready, 1'b0);
      end
    join
    check_val("b2b2_data",  rx_data, 8'h0F);
    check_val("b2b2_ready", rx_data_ready, 1'b1);
    check_val("b2b2_ferr",  frame_err, 1'b0);
    stop_bit = 2'd0;

    // Reset asserted inside data bit 4 of a frame.
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    rx = 1'b0;
    repeat (5) @(posedge clk_sample);
    #3 rst = 1'b1;
    #1;
    check_val("mid_rst_data",  rx_data, 8'h00);
    check_val("mid_rst_ready", rx_data_ready, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk_sample);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk_sample);
    #1;
    send_frame(8'h81, 1'b0, 1'b0, 16, -1);
    check_val("post_rst_data",  rx_data, 8'h81);
    check_val("post_rst_ready", rx_data_ready, 1'b1);
    check_val("post_rst_ferr",  frame_err, 1'b0);

    // One-tick glitch at the centre of data bit 0.
    send_frame(8'h5A, 1'b0, 1'b0, 16, 0);
    check_val("bit_glitch_data", rx_data, GLITCH_EXP);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have port clk_sample, input, 1 bit: 16x baud sample clock.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-004 SHALL have port parity_mode, input, 2 bits: 0 none, 1 even, 2 odd, 3 treated as none.
REQ-005 SHALL have port stop_bit, input, 2 bits: 0 one stop bit (16 ticks), 1 1.5 stop bits (24 ticks), 2 or 3 two stop bits (32 ticks).
REQ-006 SHALL have port rx_data, output, 8 bits: last received byte.
REQ-007 SHALL have port rx_data_ready, output, 1 bit: level, high while rx_data is valid and new.
REQ-008 SHALL have port parity_err, output, 1 bit: parity mismatch on the frame in rx_data.
REQ-009 SHALL have port frame_err, output, 1 bit: first stop bit sampled low.
REQ-010 SHALL have port break_det, output, 1 bit: all data, parity and stop samples low.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer on clk_sample; all decisions use the synchronized value rx_s.
REQ-012 SHALL implement the states IDLE, START, DATA, PARITY, STOP with a 5-bit tick counter and a 3-bit bit index.
REQ-013 IDLE->START SHALL occur on rx_s high-to-low transition, with the tick counter cleared.
REQ-014 In START at tick 8, rx_s low SHALL go to DATA (start validated); rx_s high SHALL return to IDLE (glitch rejected, no outputs change).
REQ-015 On start validation, the block SHALL latch parity_mode and stop_bit for the whole frame; mid-frame changes SHALL be ignored.
REQ-016 On start validation, the block SHALL clear rx_data_ready, parity_err, frame_err and break_det.
REQ-017 DATA SHALL sample 8 bits LSB first, each at tick 8 of its 16-tick bit period, then enter PARITY if parity is enabled, else STOP.
REQ-018 Expected parity SHALL be XOR(data) for even and ~XOR(data) for odd; parity_err SHALL be set on mismatch.
REQ-019 STOP SHALL sample at tick 8 of the first stop bit; a low sample SHALL set frame_err.
REQ-020 The cycle after the stop sample, rx_data SHALL load the shift register and rx_data_ready SHALL rise; errors SHALL update in the same cycle.
REQ-021 break_det SHALL be set when data = 0x00, the parity sample is 0 (if enabled) and the stop sample is 0; frame_err SHALL also be set.
REQ-022 rx_data_ready SHALL stay high until the next validated start bit; bytes are never dropped by the block itself (overrun handled downstream).
REQ-023 STOP SHALL remain for the full latched stop length, then go to IDLE.
REQ-024 If frame_err is set, the block SHALL wait in IDLE for rx_s high before accepting a new falling edge.
REQ-025 Latency SHALL be 2 cycles (synchronizer) plus 16*(1+8+P)+8+1 ticks from the start-bit falling edge to rx_data_ready, where P is 1 with parity and 0 without.

Reset
REQ-026 rst high SHALL asynchronously force IDLE, counters to 0, synchronizer flops to 1, rx_data to 0x00, and rx_data_ready, parity_err, frame_err and break_det to 0.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release, the first frame SHALL require a fresh falling edge.

Configuration
REQ-028 With UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of samples at ticks 7, 8 and 9, with the decision at tick 9.
REQ-029 Without UART_RX_MAJORITY_EN, the single sample at tick 8 SHALL be used and all decisions occur at tick 8.

Verification
REQ-030 Send 0xA5, no parity, 1 stop -> rx_data=0xA5, rx_data_ready=1, all error flags 0; latency per REQ-025.
REQ-031 Send 0x3C, even parity, with the parity bit forced to 1 -> rx_data=0x3C, parity_err=1; the same with odd parity and parity bit 1 -> parity_err=0.
REQ-032 Hold rx low for 4 ticks then high -> no state change out of IDLE, rx_data_ready stays 0.
REQ-033 Hold rx low for 12 bit times -> rx_data=0x00, frame_err=1, break_det=1; no new frame until rx returns high.
REQ-034 Send 0x55 then 0x0F back-to-back with 2 stop bits -> rx_data_ready falls at the second start validation and rises again with 0x0F.
REQ-035 Assert rst during bit 4 of a frame -> outputs 0 immediately; the next clean frame 0x81 is received correctly.
REQ-036 With UART_RX_MAJORITY_EN defined, a 1-tick glitch at tick 8 of a data bit -> bit value unaffected; without the macro -> bit corrupted.
